// File: rtl/bp_cce_ucode_loader.sv
// CCE microcode loader: streams boot instructions into the instruction RAM over the
// cfg ucode fields, reads them back to verify an XOR checksum, then selects normal mode.
module bp_cce_ucode_loader #(
  parameter int cce_instr_width_p       = 48,
  parameter int cce_pc_width_p          = 8,
  parameter int num_cce_instr_ram_els_p = 256
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [cce_pc_width_p:0]      count_i,
  input  logic                         ucode_v_i,
  input  logic [cce_instr_width_p-1:0] ucode_data_i,
  output logic                         ucode_ready_o,
  output logic                         cce_ucode_w_v_o,
  output logic                         cce_ucode_r_v_o,
  output logic [cce_pc_width_p-1:0]    cce_ucode_addr_o,
  output logic [cce_instr_width_p-1:0] cce_ucode_data_o,
  input  logic [cce_instr_width_p-1:0] ucode_rdata_i,
  output logic                         cce_mode_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  // Counter is one bit wider than the address so a full-depth count fits.
  localparam int CW = cce_pc_width_p + 1;
  localparam logic [CW-1:0] ELS_C = CW'(num_cce_instr_ram_els_p);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [2:0]                   state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [CW-1:0]                cnt_max_q, cnt_max_d;
  logic [cce_instr_width_p-1:0] wr_sum_q, wr_sum_d;
  logic [cce_instr_width_p-1:0] rd_sum_q, rd_sum_d;
  logic                         rv_q;

  logic          in_load_c, in_read_c, last_c, can_start_c, sum_ok_c;
  logic [CW-1:0] count_clamp_c;

  assign in_load_c     = (state_q == S_LOAD);
  assign in_read_c     = (state_q == S_READ);
  assign last_c        = (cnt_q == cnt_max_q - ONE_C);
  assign can_start_c   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
  assign count_clamp_c = (count_i > ELS_C) ? ELS_C : count_i;
  // In CHECK the final read word is still on ucode_rdata_i and not yet folded in.
  assign sum_ok_c      = ((rd_sum_q ^ ucode_rdata_i) == wr_sum_q);

  assign ucode_ready_o    = in_load_c;
  assign cce_ucode_w_v_o  = in_load_c & ucode_v_i;
  assign cce_ucode_r_v_o  = in_read_c;
  assign cce_ucode_addr_o = (in_load_c || in_read_c) ? cnt_q[cce_pc_width_p-1:0] : '0;
  assign cce_ucode_data_o = in_load_c ? ucode_data_i : '0;
  assign cce_mode_o       = (state_q == S_DONE);
  assign done_o           = (state_q == S_DONE);
  assign error_o          = (state_q == S_ERROR);
  assign busy_o           = in_load_c || in_read_c || (state_q == S_CHECK);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_max_d = cnt_max_q;
    wr_sum_d  = wr_sum_q;
    rd_sum_d  = rv_q ? (rd_sum_q ^ ucode_rdata_i) : rd_sum_q;
    case (state_q)
      S_LOAD: begin
        if (cce_ucode_w_v_o) begin
          wr_sum_d = wr_sum_q ^ ucode_data_i;
          if (last_c) begin
            cnt_d   = '0;
            state_d = S_READ;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
      end
      S_READ: begin
        cnt_d = cnt_q + ONE_C;
        if (last_c) state_d = S_CHECK;
      end
      S_CHECK: state_d = sum_ok_c ? S_DONE : S_ERROR;
      default: begin
        if (can_start_c && start_i) begin
          cnt_max_d = count_clamp_c;
          cnt_d     = '0;
          wr_sum_d  = '0;
          rd_sum_d  = '0;
          state_d   = (count_clamp_c == '0) ? S_DONE : S_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cnt_max_q <= '0;
      wr_sum_q  <= '0;
      rd_sum_q  <= '0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cnt_max_q <= cnt_max_d;
      wr_sum_q  <= wr_sum_d;
      rd_sum_q  <= rd_sum_d;
      rv_q      <= cce_ucode_r_v_o;
    end
  end

endmodule
